// File: rtl/myram_wport_arb.sv
// Write-port front end for the simple dual-port block RAM: post-reset clear sweep, then A/B write arbitration.
// Clear sweep is built only when MYRAM_WPORT_CLEAR_EN is defined; otherwise the block starts directly in RUN.
module myram_wport_arb #(
    parameter int                         MY_NUMBER     = 512,
    parameter int                         MY_DATA_WIDTH = 32,
    parameter logic [MY_DATA_WIDTH-1:0]   INIT_VALUE    = '0,
    parameter int                         STARVE_LIMIT  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [$clog2(MY_NUMBER)-1:0]  a_addr,
    input  logic [MY_DATA_WIDTH-1:0]      a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [$clog2(MY_NUMBER)-1:0]  b_addr,
    input  logic [MY_DATA_WIDTH-1:0]      b_data,
    output logic                          wen,
    output logic [$clog2(MY_NUMBER)-1:0]  wAddr,
    output logic [MY_DATA_WIDTH-1:0]      wdata,
    output logic                          init_done
);

    localparam int         AW         = $clog2(MY_NUMBER);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    logic                     run;
    logic                     clr_wr;
    logic                     init_set;
    logic [AW-1:0]            clr_addr;
    logic [3:0]               starve;
    logic                     starve_hit;
    logic                     a_acc;
    logic                     b_acc;
    logic                     wen_p1;
    logic [AW-1:0]            waddr_p1;
    logic [MY_DATA_WIDTH-1:0] wdata_p1;
    logic                     init_done_p1;

`ifdef MYRAM_WPORT_CLEAR_EN
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MY_NUMBER - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) cnt <= cnt + AW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && cnt == LAST_ADDR) state_nxt = RUN;
    end

    always_comb begin
        run      = (state == RUN);
        clr_wr   = (state == CLEAR);
        clr_addr = cnt;
        init_set = (state == CLEAR) && (cnt == LAST_ADDR);
    end
`else
    logic run_q;

    // Without the sweep the RAM is usable as soon as reset is released.
    always_ff @(posedge clk) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= 1'b1;
    end

    assign run      = run_q;
    assign clr_wr   = 1'b0;
    assign clr_addr = '0;
    assign init_set = 1'b1;
`endif

    // A has priority unless B has lost STARVE_LIMIT cycles in a row.
    assign starve_hit = (starve >= STARVE_LIM);
    assign a_ready    = run & ~(starve_hit & b_valid);
    assign b_ready    = run & (~a_valid | starve_hit);
    assign a_acc      = a_valid & a_ready;
    assign b_acc      = b_valid & b_ready;

    always_ff @(posedge clk) begin
        if (rst)                             starve <= '0;
        else if (run & b_valid & ~b_ready)   starve <= starve + 4'd1;
        else                                 starve <= '0;
    end

    // p1: registered RAM write port
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_p1       <= 1'b0;
            waddr_p1     <= '0;
            wdata_p1     <= '0;
            init_done_p1 <= 1'b0;
        end else begin
            wen_p1       <= clr_wr | a_acc | b_acc;
            init_done_p1 <= init_done_p1 | init_set;
            if (clr_wr) begin
                waddr_p1 <= clr_addr;
                wdata_p1 <= INIT_VALUE;
            end else if (a_acc) begin
                waddr_p1 <= a_addr;
                wdata_p1 <= a_data;
            end else if (b_acc) begin
                waddr_p1 <= b_addr;
                wdata_p1 <= b_data;
            end
        end
    end

    assign wen       = wen_p1;
    assign wAddr     = waddr_p1;
    assign wdata     = wdata_p1;
    assign init_done = init_done_p1;

endmodule

// File: tb/tb_myram_wport_arb.sv
// Self-checking bench for myram_wport_arb: directed steps plus randomized client traffic against a reference model.
// Expectations follow MYRAM_WPORT_CLEAR_EN exactly as the design build does.
module tb_myram_wport_arb;

    localparam int          N    = 8;
    localparam int          DW   = 32;
    localparam int          AW   = 3;
    localparam int          LIM  = 4;
    localparam logic [31:0] INIT = 32'hDEAD_BEEF;
`ifdef MYRAM_WPORT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr, wAddr;
    logic [DW-1:0] a_data, b_data, wdata;
    logic          wen, init_done;

    always #5 clk = ~clk;

    myram_wport_arb #(
        .MY_NUMBER    (N),
        .MY_DATA_WIDTH(DW),
        .INIT_VALUE   (INIT),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .wen      (wen),
        .wAddr    (wAddr),
        .wdata    (wdata),
        .init_done(init_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: phase flag, sweep position, loss streak, expected port values and RAM image.
    bit            m_run, m_done, m_wen;
    int            m_next_clear, m_starve;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_mem [N];
    logic [DW-1:0] d_mem [N];
    bit            last_a_acc, last_b_acc;

    function automatic bit m_hit();
        return m_starve >= LIM;
    endfunction

    function automatic bit m_ar();
        return m_run && !(m_hit() && b_valid);
    endfunction

    function automatic bit m_br();
        return m_run && (!a_valid || m_hit());
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        chk("a_ready", a_ready, m_ar());
        chk("b_ready", b_ready, m_br());
        chk("wen", wen, m_wen);
        chk("wAddr", wAddr, m_waddr);
        chk("wdata", wdata, m_wdata);
        chk("init_done", init_done, m_done);
        if (wen === 1'b1) d_mem[wAddr] = wdata;
    endtask

    task automatic model_step();
        bit ar, br;
        ar = m_ar();
        br = m_br();
        last_a_acc = 1'b0;
        last_b_acc = 1'b0;
        if (rst) begin
            m_run = 0; m_done = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
            m_next_clear = 0; m_starve = 0;
        end else if (!m_run) begin
            m_starve = 0;
            if (CLR) begin
                m_wen   = 1'b1;
                m_waddr = AW'(m_next_clear);
                m_wdata = INIT;
                m_mem[m_next_clear] = INIT;
                if (m_next_clear == N - 1) begin
                    m_run  = 1'b1;
                    m_done = 1'b1;
                end
                m_next_clear++;
            end else begin
                m_run  = 1'b1;
                m_done = 1'b1;
                m_wen  = 1'b0;
            end
        end else begin
            last_a_acc = a_valid && ar;
            last_b_acc = b_valid && br;
            m_wen = last_a_acc || last_b_acc;
            if (last_a_acc) begin
                m_waddr = a_addr; m_wdata = a_data; m_mem[a_addr] = a_data;
            end else if (last_b_acc) begin
                m_waddr = b_addr; m_wdata = b_data; m_mem[b_addr] = b_data;
            end
            m_starve = (b_valid && !br) ? m_starve + 1 : 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    initial begin
        int acc;
        rst = 1'b1;
        a_valid = 0; a_addr = '0; a_data = '0;
        b_valid = 0; b_addr = '0; b_data = '0;
        @(posedge clk);
        model_step();
        #1;
        cycle();
        chk("rst_wen", wen, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_a_ready", a_ready, 0);

        // Release reset; cycle k is the cycle after the k-th edge with rst low.
        rst = 1'b0;
        cyc = 0;
        cycle();
        chk("c1_wen", wen, CLR);
        chk("c1_wAddr", wAddr, 0);
        chk("c1_init_done", init_done, !CLR);
        cycle();

        // Refill request held from cycle 2 until accepted.
        a_valid = 1; a_addr = 3; a_data = 5;
        acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            cycle();
            if (last_a_acc) acc = cyc - 1;
        end
        a_valid = 0;
        chk("a_accept_cycle", acc, CLR ? N : 2);
        chk("a_write_wen", wen, 1);
        chk("a_write_addr", wAddr, 3);
        chk("a_write_data", wdata, 5);

        // Both clients continuously: A wins four times, then B.
        a_valid = 1; a_addr = 1; a_data = 32'h1111_0001;
        b_valid = 1; b_addr = 2; b_data = 32'h2222_0002;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("arb_b_ready", b_ready, (i % 5) == 4);
            chk("arb_a_ready", a_ready, (i % 5) != 4);
            cycle();
        end

        // Store client alone: accepted every cycle, three writes to addr 7.
        a_valid = 0;
        b_addr = 7; b_data = 9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("b_only_ready", b_ready, 1);
            cycle();
            chk("b_only_wen", wen, 1);
            chk("b_only_addr", wAddr, 7);
            chk("b_only_data", wdata, 9);
        end
        b_valid = 0;
        cycle();

        // Random traffic; each client holds its request until accepted.
        for (int i = 0; i < 400; i++) begin
            if (!a_valid || last_a_acc) begin
                a_valid = ($urandom_range(0, 9) < 8);
                a_addr  = AW'($urandom_range(0, N - 1));
                a_data  = $urandom;
            end
            if (!b_valid || last_b_acc) begin
                b_valid = ($urandom_range(0, 9) < 6);
                b_addr  = AW'($urandom_range(0, N - 1));
                b_data  = $urandom;
            end
            cycle();
        end

        // Reset in RUN with a request that would be accepted: it must be dropped.
        a_valid = 1; a_addr = 4; a_data = 32'h0000_00AA;
        b_valid = 0;
        rst = 1'b1;
        cycle();
        chk("rst_run_wen", wen, 0);
        chk("rst_run_init_done", init_done, 0);
        a_valid = 0;
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 5; i++) cycle();

        // Reset at sweep cycle 5, then the sweep restarts from address 0.
        rst = 1'b1;
        cycle();
        chk("rst_sweep_wen", wen, 0);
        chk("rst_sweep_init_done", init_done, 0);
        rst = 1'b0;
        cyc = 0;
        cycle();
        chk("restart_wen", wen, CLR);
        chk("restart_wAddr", wAddr, 0);
        for (int i = 0; i < N + 3; i++) cycle();

        for (int i = 0; i < N; i++) chk("ram_image", d_mem[i], m_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
